// File: rtl/warp_pkg.sv
// Shared warp-engine constants and memory request type.
package warp_pkg;

    localparam int REQ_ID_FETCH     = 0;
    localparam int REQ_ID_LSU       = 1;
    localparam int WARP_MEM_NUM_REQ = 2;
    localparam int WARP_ADDR_W      = 32;
    localparam int WARP_DATA_W      = 32;

    typedef struct packed {
        logic [WARP_ADDR_W-1:0] addr;
        logic                   write;
        logic [WARP_DATA_W-1:0] data;
    } warp_mem_req_t;

endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that
// advances past the winner only when the grant is taken.
module warp_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr} + (IDW+1)'(off);
            if (cand >= (IDW+1)'(NUM_REQ))
                cand = cand - (IDW+1)'(NUM_REQ);
            if (!found && req[cand[IDW-1:0]]) begin
                found                  = 1'b1;
                grant_idx              = cand[IDW-1:0];
                grant[cand[IDW-1:0]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/warp_mem_arbiter.sv
// Shares one memory port among NUM_REQ requesters; read responses are routed
// back in order using a FIFO of requester IDs.
module warp_mem_arbiter
    import warp_pkg::*;
#(
    parameter int NUM_REQ         = WARP_MEM_NUM_REQ,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              resp_valid,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    output logic                            mem_req_write,
    output logic [DATA_WIDTH-1:0]           mem_req_data,
    input  logic                            mem_resp_valid,
    output logic                            mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]           mem_resp_data,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                            err_unexpected_resp
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] data;
    } out_req_t;

    out_req_t             out_q, in_sel;
    logic                 out_valid;
    logic                 can_load, accept, push, pop, empty, full;
    logic [NUM_REQ-1:0]   eligible, grant;
    logic [IDW-1:0]       grant_idx, head;
    logic [IDW-1:0]       id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = id_mem[rd_ptr];
    assign pop   = mem_resp_valid & !empty & resp_ready[head];

    // A pop in the same cycle frees a slot, so a full FIFO still admits a read.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_valid[i] & (req_write[i] | !full | pop);
    end

    warp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (eligible),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign can_load  = !out_valid | mem_req_ready;
    assign req_ready = grant & {NUM_REQ{can_load}};
    assign accept    = |req_ready;
    assign push      = accept & !req_write[grant_idx];

    always_comb begin
        in_sel.addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        in_sel.write = req_write[grant_idx];
        in_sel.data  = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= in_sel;
        end else if (mem_req_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign mem_req_valid = out_valid;
    assign mem_req_addr  = out_q.addr;
    assign mem_req_write = out_q.write;
    assign mem_req_data  = out_q.data;

    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Responses with no owner are swallowed so memory never stalls on them.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_unexpected_resp <= 1'b0;
        else if (mem_resp_valid & empty)
            err_unexpected_resp <= 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (mem_resp_valid & !empty)
            resp_valid[head] = 1'b1;
    end

    assign resp_data      = mem_resp_data;
    assign mem_resp_ready = empty | resp_ready[head];
    assign outstanding    = count;

endmodule

// File: tb/tb_warp_mem_arbiter.sv
// Scoreboard bench: queue-based reference model of grant order, request
// register contents, read-ID routing and the unexpected-response flag.
module tb_warp_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] data;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   resp_data, mem_req_data, mem_resp_data;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_valid, mem_req_ready, mem_req_write;
    logic            mem_resp_valid, mem_resp_ready, err_unexpected_resp;
    logic [CW-1:0]   outstanding;

    always #5 clk = ~clk;

    warp_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // stimulus sources, memory model and scoreboard queues
    txn_t          src_q [N][$];
    txn_t          exp_mem_q[$];
    int            exp_id_q[$];
    logic [DW-1:0] mem_rd_q[$];
    logic [DW-1:0] data_q[$];

    int  mreq_prob, rready_prob, resp_prob;
    bit  resp_en, resp_fired;
    int  inj_req = 0, inj_done = 0;
    int  rr, m_g, m_head, mi;
    bit  m_err, m_pop;
    logic [N-1:0] m_grant, exp_rv;
    int  acc_cnt[N], rsp_cnt[N];
    int  cyc = 0, first_acc, last_acc;

    // driver: present source heads and memory behaviour just after the edge
    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
        resp_ready = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    req_valid[i]          = 1'b1;
                    req_addr[i*AW +: AW]  = src_q[i][0].addr;
                    req_write[i]          = src_q[i][0].write;
                    req_data[i*DW +: DW]  = src_q[i][0].data;
                end else begin
                    req_valid[i] = 1'b0;
                end
                resp_ready[i] = ($urandom_range(99) < rready_prob);
            end
            mem_req_ready = ($urandom_range(99) < mreq_prob);
            if (inj_req != inj_done) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hBAD0BAD0;
                inj_done++;
            end else if (resp_en && mem_rd_q.size() > 0 &&
                         ((mem_resp_valid && !resp_fired) || $urandom_range(99) < resp_prob)) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rd_q[0];
            end else begin
                mem_resp_valid = 1'b0;
            end
        end
    end

    // monitor + reference model, evaluated mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_mem_q.delete();
            exp_id_q.delete();
            rr    = 0;
            m_err = 1'b0;
            resp_fired = 1'b0;
        end else begin
            m_pop   = mem_resp_valid && exp_id_q.size() > 0 && resp_ready[exp_id_q[0]];
            m_grant = '0;
            m_g     = -1;
            if (exp_mem_q.size() == 0 || mem_req_ready) begin
                for (int k = 0; k < N; k++) begin
                    mi = (rr + k) % N;
                    if (m_g < 0 && req_valid[mi] && (req_write[mi] || exp_id_q.size() < MO || m_pop))
                        m_g = mi;
                end
            end
            if (m_g >= 0) m_grant[m_g] = 1'b1;

            chk("req_ready", req_ready, m_grant);
            chk("mem_req_valid", mem_req_valid, exp_mem_q.size() != 0);
            if (exp_mem_q.size() != 0) begin
                chk("mem_req_addr", mem_req_addr, exp_mem_q[0].addr);
                chk("mem_req_write", mem_req_write, exp_mem_q[0].write);
                chk("mem_req_data", mem_req_data, exp_mem_q[0].data);
            end
            chk("outstanding", outstanding, exp_id_q.size());
            chk("err_flag", err_unexpected_resp, m_err);

            if (mem_resp_valid) begin
                if (exp_id_q.size() == 0) begin
                    chk("drop_resp_valid", resp_valid, 0);
                    chk("drop_mem_resp_ready", mem_resp_ready, 1);
                    m_err = 1'b1;
                end else begin
                    m_head = exp_id_q[0];
                    exp_rv = '0;
                    exp_rv[m_head] = 1'b1;
                    chk("resp_valid", resp_valid, exp_rv);
                    chk("mem_resp_ready", mem_resp_ready, resp_ready[m_head]);
                    if (mem_rd_q.size() > 0)
                        chk("resp_data", resp_data, mem_rd_q[0]);
                    if (resp_ready[m_head]) rsp_cnt[m_head]++;
                end
            end else begin
                chk("resp_valid_idle", resp_valid, 0);
            end

            // advance model and environment across the coming edge
            resp_fired = mem_resp_valid && mem_resp_ready;
            if (m_pop) void'(exp_id_q.pop_front());
            if (exp_mem_q.size() != 0 && mem_req_ready) void'(exp_mem_q.pop_front());
            if (mem_req_valid && mem_req_ready && !mem_req_write)
                mem_rd_q.push_back(data_q.size() > 0 ? data_q.pop_front() : DW'($urandom));
            if (resp_fired && mem_rd_q.size() > 0) void'(mem_rd_q.pop_front());
            if (m_g >= 0) begin
                exp_mem_q.push_back(src_q[m_g][0]);
                if (!src_q[m_g][0].write) exp_id_q.push_back(m_g);
                rr = (m_g + 1) % N;
                acc_cnt[m_g]++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
        end
    end

    task automatic load(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        txn_t t;
        t.addr = a; t.write = w; t.data = d;
        src_q[i].push_back(t);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        int busy = 1;
        while (busy != 0 && n < budget) begin
            @(negedge clk);
            n++;
            busy = exp_mem_q.size() + exp_id_q.size() + mem_rd_q.size();
            for (int i = 0; i < N; i++) busy += src_q[i].size();
        end
        chk({nm, "_drain_in_budget"}, busy, 0);
        step(1);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; rsp_cnt[i] = 0; end
        first_acc = -1;
        last_acc  = -1;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish before 60000 cycles");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        resp_en = 1'b0;
        mreq_prob = 100; rready_prob = 100; resp_prob = 100;
        clear_stats();
        step(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected_resp, 0);
        step(1);

        // single read with known return data
        resp_en = 1'b1;
        data_q.push_back(32'hDEADBEEF);
        clear_stats();
        load(0, 32'h10, 1'b0, 32'h0);
        drain("single", 100);
        chk("single_resp_to_req0", rsp_cnt[0], 1);

        // fairness: both requesters saturated
        clear_stats();
        for (int k = 0; k < 16; k++) begin
            load(0, 32'h1000 + k*4, 1'b0, k);
            load(1, 32'h2000 + k*4, 1'b0, k);
        end
        drain("fair", 300);
        chk("fair_acc0", acc_cnt[0], 16);
        chk("fair_acc1", acc_cnt[1], 16);
        chk("fair_no_idle", last_acc - first_acc + 1, 32);

        // backpressure on the memory port
        mreq_prob = 0;
        load(1, 32'h20, 1'b1, 32'h55);
        step(2);
        load(0, 32'h30, 1'b0, 32'h0);
        repeat (5) @(negedge clk);
        chk("bp_valid", mem_req_valid, 1);
        chk("bp_addr", mem_req_addr, 32'h20);
        chk("bp_data", mem_req_data, 32'h55);
        chk("bp_req_ready", req_ready, 0);
        mreq_prob = 100;
        step(1);
        drain("bp", 100);

        // throttle at MAX_OUTSTANDING reads
        resp_en = 1'b0;
        for (int k = 0; k < 5; k++) load(0, 32'h100 + k*4, 1'b0, k);
        repeat (12) @(negedge clk);
        chk("thr_outstanding", outstanding, MO);
        chk("thr_req_ready", req_ready[0], 0);
        chk("thr_pending", src_q[0].size(), 1);
        resp_en = 1'b1;
        step(1);
        drain("thr", 100);

        // routing order with an interleaved write
        clear_stats();
        data_q.push_back(32'h1);
        data_q.push_back(32'h2);
        load(0, 32'hA0, 1'b0, 32'h0);
        step(1);
        load(1, 32'hB0, 1'b0, 32'h0);
        load(0, 32'hC0, 1'b1, 32'h77);
        drain("route", 100);
        chk("route_rsp0", rsp_cnt[0], 1);
        chk("route_rsp1", rsp_cnt[1], 1);
        chk("route_outstanding", outstanding, 0);

        // randomized traffic under random backpressure
        mreq_prob = 70; rready_prob = 70; resp_prob = 60;
        for (int k = 0; k < 40; k++)
            for (int i = 0; i < N; i++)
                load(i, $urandom, ($urandom_range(99) < 30), $urandom);
        drain("rand", 3000);
        mreq_prob = 100; rready_prob = 100; resp_prob = 100;
        step(2);

        // unexpected response with empty FIFO, sticky until reset
        inj_req++;
        repeat (4) @(negedge clk);
        chk("err_sticky", err_unexpected_resp, 1);
        step(1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_cleared", err_unexpected_resp, 0);
        step(1);

        // reset with reads in flight: stale responses must raise the error
        resp_en = 1'b0;
        load(0, 32'h400, 1'b0, 32'h0);
        load(1, 32'h500, 1'b0, 32'h0);
        begin
            int n = 0;
            while (mem_rd_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
            chk("inflight_reads_issued", mem_rd_q.size(), 2);
        end
        step(1);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_outstanding", outstanding, 0);
        step(1);
        resp_en = 1'b1;
        drain("stale", 100);
        chk("stale_err", err_unexpected_resp, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
